// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic int countWidth(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/seq_mul_step.sv
// One iteration of the shift-add multiplier: conditional add of the
// multiplicand into the accumulator, then a one-bit right shift of {acc, mq}.
module seq_mul_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_mq,
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_mq
);

    logic [WIDTH:0] w_sum;

    // The carry lands in w_sum[WIDTH]; after the shift acc's top bit is always clear.
    always_comb begin
        w_sum = i_acc;
        if (i_mq[0]) begin
            w_sum = {1'b0, i_acc[WIDTH-1:0]} + {1'b0, i_a};
        end
        o_acc = {1'b0, w_sum[WIDTH:1]};
        o_mq  = {w_sum[0], i_mq[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_mul.sv
// Sequential WIDTH x WIDTH shift-add multiplier with start/ready/done handshake.
// Define SEQ_MUL_SIGNED_EN to add the i_sgn port for two's-complement operands.
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic               i_sgn,
`endif
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_ready,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_p
);

    localparam int CW = countWidth(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               r_state;
    state_t               w_next;
    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     r_aReg;
    logic [WIDTH-1:0]     r_mq;
    logic [WIDTH:0]       r_acc;
    logic [CW-1:0]        r_count;
    logic [2*WIDTH-1:0]   r_p;
    logic [WIDTH:0]       w_accNext;
    logic [WIDTH-1:0]     w_mqNext;
    logic [WIDTH-1:0]     w_aLoad;
    logic [WIDTH-1:0]     w_bLoad;
    logic [2*WIDTH-1:0]   w_product;
    logic [2*WIDTH-1:0]   w_result;

    seq_mul_step #(.WIDTH(WIDTH)) u_step (
        .i_acc (r_acc),
        .i_mq  (r_mq),
        .i_a   (r_aReg),
        .o_acc (w_accNext),
        .o_mq  (w_mqNext)
    );

    assign w_product = {w_accNext[WIDTH-1:0], w_mqNext};

`ifdef SEQ_MUL_SIGNED_EN
    logic r_neg;
    logic w_negLoad;

    // The core always multiplies magnitudes; the sign is reapplied on the last step.
    assign w_aLoad   = (i_sgn && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_bLoad   = (i_sgn && i_b[WIDTH-1]) ? -i_b : i_b;
    assign w_negLoad = i_sgn & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
    assign w_result  = r_neg ? -w_product : w_product;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= w_negLoad;
        end
    end
`else
    assign w_aLoad  = i_a;
    assign w_bLoad  = i_b;
    assign w_result = w_product;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        o_ready  = 1'b1;
        o_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next   = RUN;
                    w_accept = 1'b1;
                end
            end
            RUN: begin
                o_ready = 1'b0;
                if (r_count == LAST) begin
                    w_next = DONE;
                    w_last = 1'b1;
                end
            end
            DONE: begin
                o_done = 1'b1;
                if (i_start) begin
                    w_next   = RUN;
                    w_accept = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // The count stops on the final step so it never has to hold the value WIDTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_aReg  <= '0;
            r_mq    <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_p     <= '0;
        end else if (w_accept) begin
            r_aReg  <= w_aLoad;
            r_mq    <= w_bLoad;
            r_acc   <= '0;
            r_count <= '0;
        end else if (r_state == RUN) begin
            r_acc <= w_accNext;
            r_mq  <= w_mqNext;
            if (w_last) begin
                r_p <= w_result;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_p = r_p;

endmodule
